// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the MIPS CPU memory arbiter slice.
package mips_cpu_bus_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUS  = 1'b1
   } state_t;

   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   // Index width for an n-entry vector; a single entry still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mips_cpu_rr_arbiter.sv
// Combinational one-hot grant: lowest index wins, or search starts at pointer.
module mips_cpu_rr_arbiter
   import mips_cpu_bus_pkg::*;
#(
   parameter int NCHAN     = 2,
   parameter int PRIO_MODE = PRIO_FIXED,
   localparam int PTR_W    = idx_width(NCHAN)
) (
   input  logic [NCHAN-1:0] req,
   input  logic [PTR_W-1:0] pointer,
   output logic [NCHAN-1:0] grant
);

   logic [PTR_W-1:0] start;

   assign start = (PRIO_MODE == PRIO_RR) ? pointer : '0;

   always_comb begin : search
      int               idx;
      logic [PTR_W-1:0] sel;
      logic             found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int k = 0; k < NCHAN; k++) begin
         idx = (int'(start) + k) % NCHAN;
         sel = PTR_W'(idx);
         if (!found && req[sel]) begin
            grant[sel] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Multi-channel request arbiter driving a single Avalon-MM master port.
//  state | meaning
//  IDLE  | no transaction held; grants a pending request and pulses req_ready
//  BUS   | registered request on the bus until waitrequest low or stall timeout
module mips_cpu_mem_arbiter
   import mips_cpu_bus_pkg::*;
#(
   parameter int NCHAN     = 2,
   parameter int DATA_W    = 32,
   parameter int PRIO_MODE = PRIO_FIXED,
   parameter int TIMEOUT   = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NCHAN-1:0]          req_valid,
   input  logic [NCHAN-1:0]          req_write,
   input  logic [NCHAN*32-1:0]       req_addr,
   input  logic [NCHAN*DATA_W-1:0]   req_wdata,
   input  logic [NCHAN*DATA_W/8-1:0] req_byteenable,
   output logic [NCHAN-1:0]          req_ready,
   output logic [NCHAN-1:0]          rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      busy,
   output logic [31:0]               address,
   output logic                      read,
   output logic                      write,
   output logic [DATA_W-1:0]         writedata,
   output logic [DATA_W/8-1:0]       byteenable,
   input  logic                      waitrequest,
   input  logic [DATA_W-1:0]         readdata
);

   localparam int BE_W     = DATA_W / 8;
   localparam int IDX_W    = idx_width(NCHAN);
   localparam int ADDR_LSB = $clog2(BE_W);
   localparam logic [31:0] ADDR_MASK = ~((32'd1 << ADDR_LSB) - 32'd1);
   localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   state_t            state;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  ptr_next;
   logic [IDX_W-1:0]  grant_idx;
   logic [NCHAN-1:0]  grant;
   logic [NCHAN-1:0]  cur_grant;
   logic              cur_write;
   logic [31:0]       cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [BE_W-1:0]   cur_be;
   logic [CNT_W-1:0]  stall_cnt;

   logic              sel_write;
   logic [31:0]       sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [BE_W-1:0]   sel_be;

   logic              accept;
   logic              in_bus;
   logic              stall_hit;
   logic              bus_done;
   logic              bus_abort;

   mips_cpu_rr_arbiter #(
      .NCHAN     (NCHAN),
      .PRIO_MODE (PRIO_MODE)
   ) u_arb (
      .req     (req_valid),
      .pointer (ptr),
      .grant   (grant)
   );

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      grant_idx = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (grant[i]) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*32 +: 32];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            sel_be    = req_byteenable[i*BE_W +: BE_W];
            grant_idx = IDX_W'(i);
         end
      end
   end

   assign ptr_next = (grant_idx == IDX_W'(NCHAN - 1)) ? '0 : grant_idx + 1'b1;

   // No acceptance is advertised while reset is held, even though state is IDLE.
   assign accept    = (state == IDLE) && (|req_valid) && !reset;
   assign req_ready = accept ? grant : '0;

   assign in_bus = (state == BUS);
   // Abort lands on the edge that ends the TIMEOUT-th stalled cycle.
   assign stall_hit = (TIMEOUT != 0) && waitrequest && (stall_cnt == CNT_LIMIT - 1'b1);
   assign bus_done  = in_bus && !waitrequest;
   assign bus_abort = in_bus && stall_hit;

   assign busy       = in_bus;
   assign read       = in_bus && !cur_write;
   assign write      = in_bus && cur_write;
   assign address    = cur_addr & ADDR_MASK;
   assign writedata  = cur_wdata;
   assign byteenable = cur_be;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         cur_grant <= '0;
         cur_write <= 1'b0;
         cur_addr  <= '0;
         cur_wdata <= '0;
         cur_be    <= '0;
         stall_cnt <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= BUS;
                  cur_grant <= grant;
                  cur_write <= sel_write;
                  cur_addr  <= sel_addr;
                  cur_wdata <= sel_wdata;
                  cur_be    <= sel_be;
                  stall_cnt <= '0;
                  if (PRIO_MODE == PRIO_RR) begin
                     ptr <= ptr_next;
                  end
               end
            end
            BUS: begin
               if (bus_done) begin
                  state     <= IDLE;
                  rsp_valid <= cur_grant;
                  rsp_rdata <= cur_write ? '0 : readdata;
               end else if (bus_abort) begin
                  state     <= IDLE;
                  rsp_valid <= cur_grant;
                  rsp_err   <= 1'b1;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench: fixed-priority instance (TIMEOUT 8) and round-robin instance
// (timeout disabled) share one stimulus set; each scenario checks its target.
module tb_mips_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_write = '0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_be = '0;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = '0;

   logic [1:0]  f_req_ready, f_rsp_valid;
   logic [31:0] f_rsp_rdata, f_address, f_writedata;
   logic        f_rsp_err, f_busy, f_read, f_write;
   logic [3:0]  f_byteenable;

   logic [1:0]  r_req_ready, r_rsp_valid;
   logic [31:0] r_rsp_rdata, r_address, r_writedata;
   logic        r_rsp_err, r_busy, r_read, r_write;
   logic [3:0]  r_byteenable;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_cpu_mem_arbiter #(
      .NCHAN(2), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT(8)
   ) u_fix (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_byteenable(req_be),
      .req_ready(f_req_ready), .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
      .rsp_err(f_rsp_err), .busy(f_busy),
      .address(f_address), .read(f_read), .write(f_write),
      .writedata(f_writedata), .byteenable(f_byteenable),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   mips_cpu_mem_arbiter #(
      .NCHAN(2), .DATA_W(32), .PRIO_MODE(1), .TIMEOUT(0)
   ) u_rr (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_byteenable(req_be),
      .req_ready(r_req_ready), .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata),
      .rsp_err(r_rsp_err), .busy(r_busy),
      .address(r_address), .read(r_read), .write(r_write),
      .writedata(r_writedata), .byteenable(r_byteenable),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   // Bus-protocol invariants hold on every cycle for both instances.
   always @(negedge clk) begin
      checks++;
      if ((f_read === 1'b1 && f_write === 1'b1) || (r_read === 1'b1 && r_write === 1'b1) ||
          (f_busy !== 1'b1 && (f_read !== 1'b0 || f_write !== 1'b0)) ||
          (r_busy !== 1'b1 && (r_read !== 1'b0 || r_write !== 1'b0))) begin
         errors++;
         $display("FAIL bus_invariant t=%0t: f rd/wr/busy=%b%b%b r rd/wr/busy=%b%b%b, required no rd+wr and none while idle",
                  $time, f_read, f_write, f_busy, r_read, r_write, r_busy);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0;
      req_write = '0;
      waitrequest = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 2'b11;
      tick();
      tick();
      settle();
      checks++;
      if (f_req_ready !== 2'b00 || r_req_ready !== 2'b00) begin
         errors++;
         $display("FAIL reset_ready: got %b/%b required 00/00", f_req_ready, r_req_ready);
      end
      checks++;
      if (f_busy !== 1'b0 || r_busy !== 1'b0 || f_read !== 1'b0 || f_write !== 1'b0 ||
          r_read !== 1'b0 || r_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_bus: busy %b/%b rd %b/%b wr %b/%b required all 0",
                  f_busy, r_busy, f_read, r_read, f_write, r_write);
      end
      checks++;
      if (f_rsp_valid !== 2'b00 || f_rsp_err !== 1'b0 || f_rsp_rdata !== 32'h0 ||
          f_address !== 32'h0 || r_rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs: rsp_valid %b/%b err %b rdata %h addr %h required zeros",
                  f_rsp_valid, r_rsp_valid, f_rsp_err, f_rsp_rdata, f_address);
      end
      req_valid = '0;
      reset = 1'b0;
   endtask

   task automatic test_read_basic();
      do_reset();
      req_addr[31:0] = 32'h0000_1003;
      req_be = 8'hFF;
      readdata = 32'hDEAD_BEEF;
      req_valid = 2'b01;
      settle();
      checks++;
      if (f_req_ready !== 2'b01) begin
         errors++;
         $display("FAIL read_accept: req_ready %b required 01", f_req_ready);
      end
      tick();
      req_valid = '0;
      req_addr[31:0] = 32'hFFFF_FFFF;
      settle();
      checks++;
      if (f_read !== 1'b1 || f_write !== 1'b0 || f_address !== 32'h0000_1000 || f_busy !== 1'b1) begin
         errors++;
         $display("FAIL read_bus: rd %b wr %b addr %h busy %b required 1 0 00001000 1",
                  f_read, f_write, f_address, f_busy);
      end
      tick();
      settle();
      checks++;
      if (f_read !== 1'b0 || f_rsp_valid !== 2'b01 || f_rsp_rdata !== 32'hDEAD_BEEF || f_rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL read_rsp: rd %b rsp_valid %b rdata %h err %b required 0 01 deadbeef 0",
                  f_read, f_rsp_valid, f_rsp_rdata, f_rsp_err);
      end
      tick();
      settle();
      checks++;
      if (f_rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL read_rsp_pulse: rsp_valid %b required 00", f_rsp_valid);
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      req_addr = {32'h0000_0200, 32'h0000_0100};
      readdata = 32'h1111_0000;
      req_valid = 2'b11;
      settle();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (f_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL fixed_grant[%0d]: req_ready %b required 01", i, f_req_ready);
         end
         tick();
         settle();
         checks++;
         if (f_address !== 32'h0000_0100 || f_read !== 1'b1) begin
            errors++;
            $display("FAIL fixed_bus[%0d]: addr %h rd %b required 00000100 1", i, f_address, f_read);
         end
         tick();
         settle();
      end
      checks++;
      if (f_rsp_valid !== 2'b01) begin
         errors++;
         $display("FAIL fixed_rsp_ch0: rsp_valid %b required 01", f_rsp_valid);
      end
      req_valid = 2'b10;
      settle();
      checks++;
      if (f_req_ready !== 2'b10) begin
         errors++;
         $display("FAIL fixed_withdraw_grant: req_ready %b required 10", f_req_ready);
      end
      tick();
      req_valid = '0;
      settle();
      checks++;
      if (f_address !== 32'h0000_0200 || f_read !== 1'b1) begin
         errors++;
         $display("FAIL fixed_bus_ch1: addr %h rd %b required 00000200 1", f_address, f_read);
      end
      tick();
      settle();
      checks++;
      if (f_rsp_valid !== 2'b10 || f_rsp_rdata !== 32'h1111_0000) begin
         errors++;
         $display("FAIL fixed_rsp_ch1: rsp_valid %b rdata %h required 10 11110000", f_rsp_valid, f_rsp_rdata);
      end
   endtask

   task automatic test_round_robin();
      int cnt0;
      int cnt1;
      logic [1:0] exp;
      cnt0 = 0;
      cnt1 = 0;
      do_reset();
      req_addr = {32'h0000_0200, 32'h0000_0100};
      req_valid = 2'b11;
      settle();
      for (int i = 0; i < 20; i++) begin
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if (r_req_ready !== exp) begin
            errors++;
            $display("FAIL rr_grant[%0d]: req_ready %b required %b", i, r_req_ready, exp);
         end
         if (r_req_ready === 2'b01) cnt0++;
         else if (r_req_ready === 2'b10) cnt1++;
         tick();
         settle();
         checks++;
         if (r_address !== ((i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200)) begin
            errors++;
            $display("FAIL rr_bus[%0d]: addr %h required %h", i, r_address,
                     (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
         end
         tick();
         settle();
      end
      checks++;
      if (cnt0 != 10 || cnt1 != 10) begin
         errors++;
         $display("FAIL rr_share: ch0 %0d ch1 %0d required 10 10", cnt0, cnt1);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_rr_idle_hold();
      do_reset();
      req_valid = 2'b01;
      settle();
      checks++;
      if (r_req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rr_single: req_ready %b required 01", r_req_ready);
      end
      tick();
      req_valid = '0;
      repeat (5) tick();
      req_valid = 2'b11;
      settle();
      checks++;
      if (r_req_ready !== 2'b10) begin
         errors++;
         $display("FAIL rr_idle_hold: req_ready %b required 10", r_req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      tick();
   endtask

   task automatic test_write_stall();
      do_reset();
      readdata = 32'hDEAD_BEEF;
      req_write = 2'b10;
      req_addr[63:32] = 32'h0000_2006;
      req_wdata[63:32] = 32'hA5A5_0001;
      req_be[7:4] = 4'h0;
      req_valid = 2'b10;
      settle();
      checks++;
      if (f_req_ready !== 2'b10) begin
         errors++;
         $display("FAIL write_accept: req_ready %b required 10", f_req_ready);
      end
      tick();
      req_valid = '0;
      req_wdata[63:32] = 32'h0;
      req_be[7:4] = 4'hF;
      for (int k = 0; k < 6; k++) begin
         waitrequest = (k < 5);
         settle();
         checks++;
         if (f_write !== 1'b1 || f_read !== 1'b0 || f_writedata !== 32'hA5A5_0001 ||
             f_byteenable !== 4'h0 || f_address !== 32'h0000_2004 || f_rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL write_hold[%0d]: wr %b rd %b wdata %h be %h addr %h rsp %b required 1 0 a5a50001 0 00002004 00",
                     k, f_write, f_read, f_writedata, f_byteenable, f_address, f_rsp_valid);
         end
         tick();
      end
      settle();
      checks++;
      if (f_write !== 1'b0 || f_rsp_valid !== 2'b10 || f_rsp_err !== 1'b0 || f_rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL write_rsp: wr %b rsp_valid %b err %b rdata %h required 0 10 0 00000000",
                  f_write, f_rsp_valid, f_rsp_err, f_rsp_rdata);
      end
      req_write = '0;
   endtask

   task automatic test_timeout();
      do_reset();
      readdata = 32'hDEAD_BEEF;
      req_addr[31:0] = 32'h0000_3000;
      req_valid = 2'b01;
      waitrequest = 1'b1;
      settle();
      checks++;
      if (f_req_ready !== 2'b01 || r_req_ready !== 2'b01) begin
         errors++;
         $display("FAIL timeout_accept: req_ready %b/%b required 01/01", f_req_ready, r_req_ready);
      end
      tick();
      req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         settle();
         checks++;
         if (f_read !== 1'b1 || f_rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL timeout_stall[%0d]: rd %b rsp_valid %b required 1 00", k, f_read, f_rsp_valid);
         end
         tick();
      end
      settle();
      checks++;
      if (f_read !== 1'b0 || f_busy !== 1'b0 || f_rsp_valid !== 2'b01 ||
          f_rsp_err !== 1'b1 || f_rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL timeout_abort: rd %b busy %b rsp_valid %b err %b rdata %h required 0 0 01 1 00000000",
                  f_read, f_busy, f_rsp_valid, f_rsp_err, f_rsp_rdata);
      end
      checks++;
      if (r_read !== 1'b1 || r_rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL timeout_disabled: rd %b rsp_valid %b required 1 00", r_read, r_rsp_valid);
      end
      tick();
      settle();
      checks++;
      if (f_rsp_valid !== 2'b00 || f_rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: rsp_valid %b err %b required 00 0", f_rsp_valid, f_rsp_err);
      end
      repeat (4) tick();
      waitrequest = 1'b0;
      tick();
      settle();
      checks++;
      if (r_rsp_valid !== 2'b01 || r_rsp_err !== 1'b0 || r_rsp_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL timeout_disabled_rsp: rsp_valid %b err %b rdata %h required 01 0 deadbeef",
                  r_rsp_valid, r_rsp_err, r_rsp_rdata);
      end
   endtask

   task automatic test_reset_mid_bus();
      do_reset();
      req_addr = {32'h0000_0200, 32'h0000_0100};
      req_valid = 2'b11;
      waitrequest = 1'b1;
      settle();
      checks++;
      if (r_req_ready !== 2'b01) begin
         errors++;
         $display("FAIL midrst_accept: req_ready %b required 01", r_req_ready);
      end
      tick();
      settle();
      checks++;
      if (r_read !== 1'b1 || r_busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_bus: rd %b busy %b required 1 1", r_read, r_busy);
      end
      tick();
      reset = 1'b1;
      tick();
      settle();
      checks++;
      if (r_read !== 1'b0 || r_write !== 1'b0 || r_busy !== 1'b0 || r_rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL midrst_drop: rd %b wr %b busy %b rsp_valid %b required 0 0 0 00",
                  r_read, r_write, r_busy, r_rsp_valid);
      end
      reset = 1'b0;
      waitrequest = 1'b0;
      settle();
      checks++;
      if (r_req_ready !== 2'b01) begin
         errors++;
         $display("FAIL midrst_pointer: req_ready %b required 01", r_req_ready);
      end
      tick();
      req_valid = '0;
      settle();
      checks++;
      if (r_rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL midrst_no_rsp: rsp_valid %b required 00", r_rsp_valid);
      end
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_fixed_priority();
      test_round_robin();
      test_rr_idle_hold();
      test_write_stall();
      test_timeout();
      test_reset_mid_bus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
